// File: rtl/inst_prefetch_queue_if.sv
// inst_prefetch_queue_if: fetch unit bundle (imem req/ack, redirect, decode valid/ready)
interface inst_prefetch_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ack;
    logic [DATA_W-1:0] im_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;
    modport master (
        output im_req, im_addr, out_valid, out_instr, out_pc,
        input  im_ack, im_data, redirect, redirect_pc, out_ready
    );
    modport slave (
        input  im_req, im_addr, out_valid, out_instr, out_pc,
        output im_ack, im_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: single-outstanding instruction fetcher feeding a flushable (instr, pc) FIFO
module inst_prefetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    inst_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    typedef enum logic [1:0] {RUN, WAIT, KILL} state_t;
    state_t            r_state, w_next_state;
    logic              r_im_req;
    logic [ADDR_W-1:0] r_im_addr, r_fetch_pc;
    logic [PW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_instr [DEPTH];
    logic [ADDR_W-1:0] r_pc [DEPTH];
    logic              w_issue, w_push, w_pop, w_valid;
    assign w_valid = r_count != '0;
    assign w_pop   = w_valid & bus.out_ready & ~bus.redirect;
    // Issue only happens in RUN, where nothing is outstanding, so count alone is the space check
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            RUN: if (!bus.redirect && r_count < FULL) begin
                w_issue      = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: if (bus.redirect) w_next_state = bus.im_ack ? RUN : KILL;
                  else if (bus.im_ack) begin
                      w_push       = 1'b1;
                      w_next_state = RUN;
                  end
            KILL: if (bus.im_ack) w_next_state = RUN;
            default: w_next_state = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_im_req   <= 1'b0;
            r_im_addr  <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_im_req   <= w_next_state != RUN;
            r_fetch_pc <= bus.redirect ? bus.redirect_pc : w_issue ? r_fetch_pc + ADDR_W'(1) : r_fetch_pc;
            if (w_issue) r_im_addr <= r_fetch_pc;
            if (bus.redirect) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                r_wptr  <= r_wptr + PW'(w_push);
                r_rptr  <= r_rptr + PW'(w_pop);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= bus.im_data;
            r_pc[r_wptr]    <= r_im_addr;
        end
    end
    assign bus.im_req    = r_im_req;
    assign bus.im_addr   = r_im_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_instr = w_valid ? r_instr[r_rptr] : '0;
    assign bus.out_pc    = w_valid ? r_pc[r_rptr] : '0;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: directed vectors plus hand sequences for redirect, backpressure and reset
module tb_inst_prefetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    inst_prefetch_queue_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    inst_prefetch_queue #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic       rdr;
        logic [7:0] rpc;
        logic       rdy;
        logic       ack;
        logic [7:0] data;
        logic       v;
        logic [7:0] pc;
        logic [7:0] ins;
        logic       req;
        logic [7:0] addr;
    } vec_t;
    vec_t vecs [17];
    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", n, got, exp);
        end
    endtask
    task automatic drive(input logic rdr, input logic [7:0] rpc, input logic rdy, input logic ack, input logic [7:0] data);
        bus.redirect    = rdr;
        bus.redirect_pc = rpc;
        bus.out_ready   = rdy;
        bus.im_ack      = ack;
        bus.im_data     = data;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_out(input string n, input logic v, input logic [7:0] pc, input logic [7:0] ins);
        chk({n, "_valid"}, {7'd0, bus.out_valid}, {7'd0, v});
        chk({n, "_pc"}, bus.out_pc, pc);
        chk({n, "_instr"}, bus.out_instr, ins);
    endtask
    task automatic chk_mem(input string n, input logic req, input logic [7:0] addr);
        chk({n, "_req"}, {7'd0, bus.im_req}, {7'd0, req});
        chk({n, "_addr"}, bus.im_addr, addr);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0; bus.im_ack = 1'b0; bus.im_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 8'h00);
        chk_mem("reset", 1'b0, 8'h00);
        rst_n = 1'b1;
    endtask
    initial begin
        int pushes;
        logic a;
        logic [7:0] d;
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 8'h01, 8'hA4, 1'b0, 8'h01};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h02};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA7, 1'b1, 8'h02, 8'hA7, 1'b0, 8'h02};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA6, 1'b1, 8'h03, 8'hA6, 1'b0, 8'h03};
        vecs[8]  = '{1'b1, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFE};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5B, 1'b1, 8'hFE, 8'h5B, 1'b0, 8'hFE};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hFF, 8'h5A, 1'b0, 8'hFF};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 8'hA5, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h01};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 8'h01, 8'hA4, 1'b0, 8'h01};
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rdr, vecs[i].rpc, vecs[i].rdy, vecs[i].ack, vecs[i].data);
            chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].ins);
            chk_mem($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr);
        end
        // Backpressure: zero-wait memory, decode stalled
        do_reset();
        pushes = 0;
        for (int i = 0; i < 12; i++) begin
            a = bus.im_req;
            d = bus.im_addr ^ 8'hA5;
            pushes += int'(a);
            drive(1'b0, 8'h00, 1'b0, a, d);
        end
        chk("full_pushes", 8'(pushes), 8'd4);
        chk_mem("full", 1'b0, 8'h03);
        chk_out("full", 1'b1, 8'h00, 8'hA5);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("release1", 1'b0, 8'h03);
        chk_out("release1", 1'b1, 8'h01, 8'hA4);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("release2", 1'b1, 8'h04);
        chk_out("release2", 1'b1, 8'h02, 8'hA7);
        // Redirect coinciding with ack and pop, two entries queued
        drive(1'b1, 8'h10, 1'b1, 1'b1, 8'h77);
        chk_out("rdr_ack", 1'b0, 8'h00, 8'h00);
        chk_mem("rdr_ack", 1'b0, 8'h04);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("rdr_ack_refetch", 1'b1, 8'h10);
        chk_out("rdr_ack_refetch", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hB5);
        chk_out("rdr_ack_first", 1'b1, 8'h10, 8'hB5);
        // Redirect while waiting: stale ack must be dropped
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("kill_issue", 1'b1, 8'h11);
        drive(1'b1, 8'h40, 1'b1, 1'b0, 8'h00);
        chk_mem("kill_enter", 1'b1, 8'h11);
        chk_out("kill_enter", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("kill_hold", 1'b1, 8'h11);
        chk_out("kill_hold", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hFF);
        chk_mem("kill_ack", 1'b0, 8'h11);
        chk_out("kill_ack", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        chk_mem("kill_refetch", 1'b1, 8'h40);
        chk_out("kill_refetch", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hE5);
        chk_out("kill_first", 1'b1, 8'h40, 8'hE5);
        // Async reset in WAIT with three entries queued
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hE4);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hE7);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        chk_mem("pre_rst", 1'b1, 8'h43);
        chk_out("pre_rst", 1'b1, 8'h40, 8'hE5);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 8'h00, 8'h00);
        chk_mem("mid_rst", 1'b0, 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h66);
        chk_mem("post_rst", 1'b1, 8'h00);
        chk_out("post_rst", 1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
        chk_out("post_rst_first", 1'b1, 8'h00, 8'hA5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
